// File: rtl/pcie_sym_pkg.sv
// -----------------------------------------------------------------------------
// pcie_sym_pkg
// Shared definitions for the PCIe symbol-stream framing monitor:
//   - 8b/10b K-code values used by the framing parser
//   - parser state enum (IDLE / TLP / DLLP / OS)
//   - per-symbol event struct produced by one parser step
//   - count8(): population count of an 8-bit event vector (one bit per lane)
// -----------------------------------------------------------------------------
package pcie_sym_pkg;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    localparam int         LANES     = 8;
    localparam logic [15:0] DLLP_SYMS = 16'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TLP  = 2'd1,
        ST_DLLP = 2'd2,
        ST_OS   = 2'd3
    } sym_state_t;

    // Field order fixes the bit order of the packed 5-bit event bus.
    typedef struct packed {
        logic tlp;   // good TLP closed by END
        logic dllp;  // good DLLP closed by END
        logic nul;   // TLP nullified by EDB
        logic skp;   // first SKP of an ordered set
        logic err;   // framing error
    } sym_evt_t;

    function automatic logic [3:0] count8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pcie_sym_monitor_step.sv
// -----------------------------------------------------------------------------
// pcie_sym_step
// Purely combinational single-symbol step of the framing parser. The top
// chains eight of these so a whole 8-symbol beat is parsed in one cycle.
//
// Ports
//   state_in  [1:0]  parser state before this symbol (sym_state_t encoding)
//   len_in    [15:0] frame length so far (TLP/DLLP: symbols incl. STP/SDP;
//                    OS: 0 = no SKP seen yet, 1 = SKP already counted)
//   sym       [7:0]  symbol byte
//   sym_k            K flag of the symbol
//   state_out [1:0]  parser state after this symbol
//   len_out   [15:0] frame length after this symbol (0 whenever IDLE)
//   evt_out   [4:0]  sym_evt_t events raised by this symbol
//   close_len [15:0] length of the TLP closed here (valid with evt tlp bit)
//
// Build option SYM_MON_DLLP_LEN_EN: DLLPs must be exactly 8 symbols SDP..END.
// -----------------------------------------------------------------------------
module pcie_sym_step
    import pcie_sym_pkg::*;
#(
    parameter int MAX_TLP_SYMS = 1100
) (
    input  logic [1:0]  state_in,
    input  logic [15:0] len_in,
    input  logic [7:0]  sym,
    input  logic        sym_k,
    output logic [1:0]  state_out,
    output logic [15:0] len_out,
    output logic [4:0]  evt_out,
    output logic [15:0] close_len
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_TLP_SYMS);

    sym_state_t  cur_st;
    sym_state_t  nxt_st;
    logic [15:0] len_nxt;
    logic [15:0] len_inc;
    sym_evt_t    ev;

    always_comb begin
        cur_st    = sym_state_t'(state_in);
        nxt_st    = cur_st;
        len_nxt   = len_in;
        ev        = '0;
        close_len = '0;
        // length including the current symbol, saturating
        len_inc   = (len_in == 16'hFFFF) ? len_in : len_in + 16'd1;

        // Any non-SKP symbol ends an ordered set and is then parsed as if
        // it had arrived in IDLE (so COM,SKP,STP opens a TLP directly).
        if (cur_st == ST_OS && !(sym_k && sym == K_SKP)) begin
            cur_st  = ST_IDLE;
            nxt_st  = ST_IDLE;
            len_nxt = '0;
        end

        case (cur_st)
            ST_IDLE: begin
                if (sym_k) begin
                    case (sym)
                        K_STP: begin nxt_st = ST_TLP;  len_nxt = 16'd1; end
                        K_SDP: begin nxt_st = ST_DLLP; len_nxt = 16'd1; end
                        K_COM: begin nxt_st = ST_OS;   len_nxt = 16'd0; end
                        K_END, K_EDB: ev.err = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_TLP: begin
                if (sym_k) begin
                    case (sym)
                        // a new start inside a TLP is an error but still opens a frame
                        K_STP: begin ev.err = 1'b1; nxt_st = ST_TLP;  len_nxt = 16'd1; end
                        K_SDP: begin ev.err = 1'b1; nxt_st = ST_DLLP; len_nxt = 16'd1; end
                        K_END: begin
                            if (len_inc > MAX_LEN) begin
                                ev.err = 1'b1;
                            end else begin
                                ev.tlp    = 1'b1;
                                close_len = len_inc;
                            end
                            nxt_st = ST_IDLE;
                        end
                        K_EDB: begin ev.nul = 1'b1; nxt_st = ST_IDLE; end
                        default: begin ev.err = 1'b1; nxt_st = ST_IDLE; end
                    endcase
                end else if (len_inc > MAX_LEN) begin
                    ev.err = 1'b1;
                    nxt_st = ST_IDLE;
                end else begin
                    len_nxt = len_inc;
                end
            end

            ST_DLLP: begin
                if (sym_k) begin
                    if (sym == K_END) begin
`ifdef SYM_MON_DLLP_LEN_EN
                        if (len_inc == DLLP_SYMS) ev.dllp = 1'b1;
                        else                      ev.err  = 1'b1;
`else
                        ev.dllp = 1'b1;
`endif
                    end else begin
                        ev.err = 1'b1;
                    end
                    nxt_st = ST_IDLE;
                end else begin
`ifdef SYM_MON_DLLP_LEN_EN
                    // the 8th symbol must be END; data there kills the DLLP
                    if (len_inc == DLLP_SYMS) begin
                        ev.err = 1'b1;
                        nxt_st = ST_IDLE;
                    end else begin
                        len_nxt = len_inc;
                    end
`else
                    len_nxt = len_inc;
`endif
                end
            end

            ST_OS: begin
                // only SKP reaches here; count it once per ordered set
                if (len_in == 16'd0) ev.skp = 1'b1;
                len_nxt = 16'd1;
            end

            default: nxt_st = ST_IDLE;
        endcase

        if (nxt_st == ST_IDLE) len_nxt = '0;
    end

    assign state_out = nxt_st;
    assign len_out   = len_nxt;
    assign evt_out   = ev;

endmodule

// File: rtl/pcie_sym_monitor.sv
// -----------------------------------------------------------------------------
// pcie_sym_monitor
// Passive framing monitor for an 8-lane PCIe symbol stream. Each beat carries
// 8 symbols (symbol 0 earliest); the beat is parsed in one cycle by a chain of
// eight pcie_sym_step instances, and saturating event counters are updated.
// All outputs are registered: results of a beat appear one cycle later.
//
// Parameters
//   CNT_W        width of every event counter (saturating, CNT_W >= 4)
//   MAX_TLP_SYMS TLP longer than this (STP..END inclusive) is a framing error
//   L0_STATE     ltssm encoding of L0; parsing only happens in this state
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   clr                   synchronous clear, same effect as RESET
//   sym_val               beat valid
//   sym_data [63:0]       symbol i = sym_data[8i+7:8i]
//   sym_datak [7:0]       K flag of symbol i
//   ltssm [4:0]           current LTSSM state
//   tlp_cnt/dllp_cnt/null_cnt/skp_cnt/err_cnt  saturating event counters
//   tlp_done              pulse: good TLP(s) closed in the previous beat
//   tlp_len [15:0]        length of the last good TLP closed
//   err_pulse             pulse: framing error(s) in the previous beat
//   dbg_state [1:0]       parser state carried between beats (sym_state_t)
//
// Beat transfer: sym_val alone qualifies a beat. There is no ready; every
// beat with sym_val=1 is consumed on the rising edge it is sampled, and a
// beat with sym_val=0 leaves the parser state untouched.
//
// Build option SYM_MON_DLLP_LEN_EN: enforce 8-symbol DLLPs (see pcie_sym_step).
// -----------------------------------------------------------------------------
module pcie_sym_monitor
    import pcie_sym_pkg::*;
#(
    parameter int         CNT_W        = 16,
    parameter int         MAX_TLP_SYMS = 1100,
    parameter logic [4:0] L0_STATE     = 5'h0F
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             sym_val,
    input  logic [63:0]      sym_data,
    input  logic [7:0]       sym_datak,
    input  logic [4:0]       ltssm,
    output logic [CNT_W-1:0] tlp_cnt,
    output logic [CNT_W-1:0] dllp_cnt,
    output logic [CNT_W-1:0] null_cnt,
    output logic [CNT_W-1:0] skp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             tlp_done,
    output logic [15:0]      tlp_len,
    output logic             err_pulse,
    output logic [1:0]       dbg_state
);

    sym_state_t  state_q;
    logic [15:0] len_q;

    // state/length threaded through the eight lanes of one beat
    logic [1:0]  st_chain  [0:LANES];
    logic [15:0] len_chain [0:LANES];
    logic [4:0]  evt_bits  [0:LANES-1];
    logic [15:0] close_len [0:LANES-1];

    assign st_chain[0]  = state_q;
    assign len_chain[0] = len_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pcie_sym_step #(
            .MAX_TLP_SYMS (MAX_TLP_SYMS)
        ) u_step (
            .state_in  (st_chain[g]),
            .len_in    (len_chain[g]),
            .sym       (sym_data[8*g +: 8]),
            .sym_k     (sym_datak[g]),
            .state_out (st_chain[g+1]),
            .len_out   (len_chain[g+1]),
            .evt_out   (evt_bits[g]),
            .close_len (close_len[g])
        );
    end

    // Gather per-lane events into one vector per event kind, and pick the
    // length of the latest good TLP in the beat (highest lane wins).
    sym_evt_t    ev_tmp;
    logic [7:0]  v_tlp, v_dllp, v_null, v_skp, v_err;
    logic [15:0] last_len;

    always_comb begin
        ev_tmp   = '0;
        v_tlp    = '0;
        v_dllp   = '0;
        v_null   = '0;
        v_skp    = '0;
        v_err    = '0;
        last_len = tlp_len;
        for (int i = 0; i < LANES; i++) begin
            ev_tmp    = sym_evt_t'(evt_bits[i]);
            v_tlp[i]  = ev_tmp.tlp;
            v_dllp[i] = ev_tmp.dllp;
            v_null[i] = ev_tmp.nul;
            v_skp[i]  = ev_tmp.skp;
            v_err[i]  = ev_tmp.err;
            if (ev_tmp.tlp) last_len = close_len[i];
        end
    end

    // Add up to 8 events; the extra top bit catches overflow so the counter
    // sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [3:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-3){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            tlp_cnt   <= '0;
            dllp_cnt  <= '0;
            null_cnt  <= '0;
            skp_cnt   <= '0;
            err_cnt   <= '0;
            tlp_done  <= 1'b0;
            tlp_len   <= '0;
            err_pulse <= 1'b0;
        end else begin
            tlp_done  <= 1'b0;
            err_pulse <= 1'b0;
            if (sym_val) begin
                if (ltssm != L0_STATE) begin
                    // link not in L0: drop any open frame, count nothing
                    state_q <= ST_IDLE;
                    len_q   <= '0;
                end else begin
                    state_q   <= sym_state_t'(st_chain[LANES]);
                    len_q     <= len_chain[LANES];
                    tlp_cnt   <= sat_add(tlp_cnt,  count8(v_tlp));
                    dllp_cnt  <= sat_add(dllp_cnt, count8(v_dllp));
                    null_cnt  <= sat_add(null_cnt, count8(v_null));
                    skp_cnt   <= sat_add(skp_cnt,  count8(v_skp));
                    err_cnt   <= sat_add(err_cnt,  count8(v_err));
                    tlp_done  <= |v_tlp;
                    err_pulse <= |v_err;
                    tlp_len   <= last_len;
                end
            end
        end
    end

    assign dbg_state = state_q;

endmodule
